// File: rtl/fp16_mult_norm_round.sv
// FP16 multiply back end: normalise the 22b mantissa product, round to nearest-even, pack binary16 + flags.
// Latency: 2 cycles (normalise register, then round/pack register); 1 beat per cycle sustained.
// Backpressure: out_ready stalls stage 2, which stalls stage 1; in_ready is the combinational advance of stage 1.
module fp16_mult_norm_round #(
  parameter int BIAS  = 15,
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*(MAN_W+1)-1:0]     in_product,
  input  logic                       in_sign_a,
  input  logic                       in_sign_b,
  input  logic [EXP_W-1:0]           in_exp_a,
  input  logic [EXP_W-1:0]           in_exp_b,
  input  logic                       in_zero,
  input  logic                       in_inf,
  input  logic                       in_nan,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_result,
  output logic                       out_overflow,
  output logic                       out_underflow,
  output logic                       out_inexact,
  output logic                       out_invalid
);

  localparam int PROD_W = 2 * (MAN_W + 1);
  // Internal exponent is wide enough to hold exp_a + exp_b - BIAS + 2 as a signed value.
  localparam int XW     = EXP_W + 3;
  localparam int RES_W  = EXP_W + MAN_W + 1;

  localparam logic [XW-1:0]    BIAS_X   = XW'(BIAS);
  localparam logic [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic [XW-1:0]    EXP_ZERO = '0;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [MAN_W-1:0] FRAC_Z   = '0;
  localparam logic [RES_W-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Stage-1 payload: normalised but unrounded value plus the special-operand flags.
  typedef struct packed {
    logic             sign;
    logic [XW-1:0]    exp;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             zero;
    logic             inf;
    logic             nan;
  } norm_t;

  // Stage-2 payload: packed result and exception flags as presented downstream.
  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             overflow;
    logic             underflow;
    logic             inexact;
    logic             invalid;
  } res_t;

  logic adv1;
  logic adv2;

  logic  s1_vld_q,  s1_vld_d;
  norm_t s1_dat_q,  s1_dat_d;
  logic  out_vld_q, out_vld_d;
  res_t  out_dat_q, out_dat_d;

  norm_t norm_new;
  res_t  res_new;

  // Rounding intermediates (stage 2).
  logic             round_up;
  logic             frac_carry;
  logic [MAN_W-1:0] frac_rnd;
  logic [XW-1:0]    exp_rnd;

  // Pipeline advance: a stage moves when it is empty or its consumer moves.
  always_comb begin
    adv2     = !out_vld_q || out_ready;
    adv1     = !s1_vld_q || adv2;
    in_ready = adv1;
  end

  // Stage 1: product sign, exponent sum and normalisation of the 1.x / 2.x mantissa.
  always_comb begin
    norm_new      = '0;
    norm_new.sign = in_sign_a ^ in_sign_b;
    // A product in [2,4) sets the top bit and bumps the exponent by one.
    norm_new.exp  = XW'(in_exp_a) + XW'(in_exp_b) - BIAS_X + XW'(in_product[PROD_W-1]);
    if (in_product[PROD_W-1]) begin
      norm_new.frac   = in_product[PROD_W-2 -: MAN_W];
      norm_new.guard  = in_product[PROD_W-2-MAN_W];
      norm_new.sticky = |in_product[PROD_W-3-MAN_W:0];
    end else begin
      norm_new.frac   = in_product[PROD_W-3 -: MAN_W];
      norm_new.guard  = in_product[PROD_W-3-MAN_W];
      norm_new.sticky = |in_product[PROD_W-4-MAN_W:0];
    end
    norm_new.zero = in_zero;
    norm_new.inf  = in_inf;
    norm_new.nan  = in_nan;
  end

  // Stage-1 register next state: load on accept, otherwise hold.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_dat_d = s1_dat_q;
    if (adv1) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_dat_d = norm_new;
      end
    end
  end

  // Stage 2: round to nearest-even; a fraction carry-out leaves frac at zero and bumps the exponent.
  always_comb begin
    round_up               = s1_dat_q.guard && (s1_dat_q.sticky || s1_dat_q.frac[0]);
    {frac_carry, frac_rnd} = {1'b0, s1_dat_q.frac} + {{MAN_W{1'b0}}, round_up};
    exp_rnd                = s1_dat_q.exp + XW'(frac_carry);
  end

  // Stage 2: exception priority and binary16 packing; the mantissa path is ignored for specials.
  always_comb begin
    res_new = '0;
    if (s1_dat_q.nan || (s1_dat_q.inf && s1_dat_q.zero)) begin
      res_new.result  = QNAN;
      res_new.invalid = 1'b1;
    end else if (s1_dat_q.inf) begin
      res_new.result = {s1_dat_q.sign, EXP_ONES, FRAC_Z};
    end else if (s1_dat_q.zero) begin
      res_new.result = {s1_dat_q.sign, {(RES_W-1){1'b0}}};
    end else if ($signed(exp_rnd) >= $signed(EXP_MAX)) begin
      res_new.result   = {s1_dat_q.sign, EXP_ONES, FRAC_Z};
      res_new.overflow = 1'b1;
      res_new.inexact  = 1'b1;
    end else if ($signed(exp_rnd) <= $signed(EXP_ZERO)) begin
      // No subnormals: anything below the smallest normal flushes to signed zero.
      res_new.result    = {s1_dat_q.sign, {(RES_W-1){1'b0}}};
      res_new.underflow = 1'b1;
      res_new.inexact   = 1'b1;
    end else begin
      res_new.result  = {s1_dat_q.sign, exp_rnd[EXP_W-1:0], frac_rnd};
      res_new.inexact = s1_dat_q.guard || s1_dat_q.sticky;
    end
  end

  // Output register next state: load when stage 2 advances with a valid beat, otherwise hold stable.
  always_comb begin
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (adv2) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_dat_d = res_new;
      end
    end
  end

  // Stage-1 state; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_dat_q <= s1_dat_d;
    end
  end

  // Output state; reset clears valid, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;
    end
  end

  // Drive ports straight from the output register.
  always_comb begin
    out_valid     = out_vld_q;
    out_result    = out_dat_q.result;
    out_overflow  = out_dat_q.overflow;
    out_underflow = out_dat_q.underflow;
    out_inexact   = out_dat_q.inexact;
    out_invalid   = out_dat_q.invalid;
  end

endmodule

// File: tb/tb_fp16_mult_norm_round.sv
// Scoreboard bench for fp16_mult_norm_round: directed vectors, expected results queued at accept,
// monitor pops and compares on every output transfer and checks hold-stability while stalled.
module tb_fp16_mult_norm_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_product = '0;
  logic        in_sign_a = 1'b0;
  logic        in_sign_b = 1'b0;
  logic [4:0]  in_exp_a = '0;
  logic [4:0]  in_exp_b = '0;
  logic        in_zero = 1'b0;
  logic        in_inf = 1'b0;
  logic        in_nan = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;
  logic        out_invalid;

  fp16_mult_norm_round dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_product    (in_product),
    .in_sign_a     (in_sign_a),
    .in_sign_b     (in_sign_b),
    .in_exp_a      (in_exp_a),
    .in_exp_b      (in_exp_b),
    .in_zero       (in_zero),
    .in_inf        (in_inf),
    .in_nan        (in_nan),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_inexact   (out_inexact),
    .out_invalid   (out_invalid)
  );

  always #5 clk = ~clk;

  // {result, overflow, underflow, inexact, invalid}
  typedef logic [19:0] exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  logic held   = 1'b0;
  exp_t last_got;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, queue its expected response.
  task automatic send(input logic [21:0] p, input logic sa, input logic sb,
                      input logic [4:0] ea, input logic [4:0] eb,
                      input logic z, input logic i, input logic n,
                      input logic [15:0] r, input logic ov, input logic un,
                      input logic ix, input logic iv);
    int w;
    @(negedge clk);
    in_product = p;
    in_sign_a  = sa;
    in_sign_b  = sb;
    in_exp_a   = ea;
    in_exp_b   = eb;
    in_zero    = z;
    in_inf     = i;
    in_nan     = n;
    in_valid   = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", w);
      in_valid = 1'b0;
    end else begin
      q.push_back({r, ov, un, ix, iv});
      n_push++;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: compare every transfer against the scoreboard; stalled outputs must not change.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    got = {out_result, out_overflow, out_underflow, out_inexact, out_invalid};
    if (rst_n && out_valid) begin
      if (held) chk("stall_hold_stable", got, last_got);
      if (out_ready) begin
        held = 1'b0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h with empty scoreboard", got);
        end else begin
          want = q.pop_front();
          n_pop++;
          chk("result_and_flags", got, want);
        end
      end else begin
        held     = 1'b1;
        last_got = got;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    // Reset state.
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result_flags", {out_result, out_overflow, out_underflow, out_inexact, out_invalid}, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function, streamed back to back with out_ready high.
    send(22'h240000, 0, 0, 15, 15, 0, 0, 0, 16'h4080, 0, 0, 0, 0); // 1.5 x 1.5
    send(22'h100000, 0, 1, 16, 16, 0, 0, 0, 16'hC400, 0, 0, 0, 0); // 2.0 x -2.0
    send(22'h180600, 0, 0, 15, 15, 0, 0, 0, 16'h3E02, 0, 0, 1, 0); // RNE tie, odd -> up
    send(22'h100000, 0, 0, 30, 30, 0, 0, 0, 16'h7C00, 1, 0, 1, 0); // overflow
    send(22'h100000, 0, 0, 1,  1,  0, 0, 0, 16'h0000, 0, 1, 1, 0); // underflow
    send(22'h000000, 0, 0, 0,  0,  1, 1, 0, 16'h7E00, 0, 0, 0, 1); // inf x zero
    send(22'h100000, 0, 0, 15, 15, 0, 0, 0, 16'h3C00, 0, 0, 0, 0); // exactly 1.0 x 1.0
    send(22'h1FFFFF, 0, 0, 15, 30, 0, 0, 0, 16'h7C00, 1, 0, 1, 0); // round carry 30 -> 31
    send(22'h1FFC00, 0, 0, 15, 30, 0, 0, 0, 16'h7BFF, 0, 0, 0, 0); // max normal, exact
    send(22'h100000, 0, 0, 7,  8,  0, 0, 0, 16'h0000, 0, 1, 1, 0); // exp exactly 0
    send(22'h100000, 0, 0, 8,  8,  0, 0, 0, 16'h0400, 0, 0, 0, 0); // min normal
    send(22'h100300, 0, 0, 15, 15, 0, 0, 0, 16'h3C01, 0, 0, 1, 0); // above half -> up
    send(22'h100200, 0, 0, 15, 15, 0, 0, 0, 16'h3C00, 0, 0, 1, 0); // tie, even -> stays
    send(22'h300400, 0, 0, 15, 15, 0, 0, 0, 16'h4200, 0, 0, 1, 0); // 2.x path, tie even
    send(22'h3FFFFF, 1, 0, 15, 15, 0, 0, 1, 16'h7E00, 0, 0, 0, 1); // NaN wins
    send(22'h3FFFFF, 1, 0, 30, 30, 0, 1, 0, 16'hFC00, 0, 0, 0, 0); // -inf, no overflow flag
    send(22'h3FFFFF, 0, 1, 1,  1,  1, 0, 0, 16'h8000, 0, 0, 0, 0); // -0, no underflow flag
    drain();

    // Stall: two beats fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    send(22'h240000, 0, 0, 15, 15, 0, 0, 0, 16'h4080, 0, 0, 0, 0);
    send(22'h100000, 0, 1, 16, 16, 0, 0, 0, 16'hC400, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("stall_in_ready_low", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    fork
      begin
        send(22'h100000, 0, 0, 15, 15, 0, 0, 0, 16'h3C00, 0, 0, 0, 0);
        send(22'h180600, 0, 0, 15, 15, 0, 0, 0, 16'h3E02, 0, 0, 1, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_no_loss_or_dup", n_pop, n_push);

    // Reset mid-stream discards in-flight beats and clears the output at once.
    out_ready = 1'b0;
    send(22'h240000, 0, 0, 15, 15, 0, 0, 0, 16'h4080, 0, 0, 0, 0);
    send(22'h100000, 0, 1, 16, 16, 0, 0, 0, 16'hC400, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_reset_out_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", out_valid, 0);
    chk("mid_reset_result_flags", {out_result, out_overflow, out_underflow, out_inexact, out_invalid}, 0);
    q.delete();
    n_pop  = 0;
    n_push = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(22'h180600, 0, 0, 15, 15, 0, 0, 0, 16'h3E02, 0, 0, 1, 0);
    drain();
    chk("post_reset_count", n_pop, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
